// File: rtl/mul_sqrt_2_if.sv
// Stream interface for mul_sqrt_2: sample in, scaled sample out, valid/ready on both sides.
interface mul_sqrt_2_if #(parameter int N = 3);
  localparam int W = 2**N;

  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sat;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_sat);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_sat);
endinterface

// File: rtl/mul_sqrt_2.sv
// x*sqrt(2) ~= x + x>>>2 + x>>>3 + x>>>5 + x>>>7, two-stage valid/ready pipeline.
// Define MUL_SQRT_2_SAT_EN to clip the result to W bits and flag it on out_sat.
module mul_sqrt_2 #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  mul_sqrt_2_if.slave  s
);
  localparam int W      = 2**N;
  localparam int STAGES = 2;
`ifdef MUL_SQRT_2_SAT_EN
  localparam int TW = W + 2;
`else
  // wrap mode keeps only the low W bits, and modular adds need no headroom
  localparam int TW = W;
`endif

  typedef struct packed {
    logic signed [TW-1:0] a;
    logic signed [TW-1:0] b;
    logic signed [TW-1:0] c;
  } s1_t;

  logic [STAGES:1]     vld_pipe;
  logic                adv1, adv2, in_xfer;
  logic signed [TW-1:0] xe, sum;
  logic signed [W-1:0] res_d, res_q;
  s1_t                 s1_d, s1_q;

  assign adv2       = ~vld_pipe[2] | s.out_ready;
  assign adv1       = ~vld_pipe[1] | adv2;
  assign in_xfer    = s.in_valid & adv1;
  assign s.in_ready = adv1;
  assign s.out_valid = vld_pipe[2];
  assign s.out_data  = res_q;

  assign xe = TW'(s.in_data);

  always_comb begin
    s1_d.a = xe + (xe >>> 2);
    s1_d.b = (xe >>> 3) + (xe >>> 5);
    s1_d.c = xe >>> 7;
  end

  assign sum = s1_q.a + s1_q.b + s1_q.c;

`ifdef MUL_SQRT_2_SAT_EN
  localparam logic signed [TW-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [TW-1:0] MINV = {3'b111, {(W-1){1'b0}}};
  logic sat_d, sat_q;

  always_comb begin
    res_d = sum[W-1:0];
    sat_d = 1'b0;
    if (sum > MAXV) begin
      res_d = MAXV[W-1:0];
      sat_d = 1'b1;
    end else if (sum < MINV) begin
      res_d = MINV[W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        sat_q <= 1'b0;
    else if (vld_pipe[1] & adv2)    sat_q <= sat_d;
  end

  assign s.out_sat = sat_q;
`else
  assign res_d     = sum;
  assign s.out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      res_q    <= '0;
    end else begin
      if (in_xfer) begin
        s1_q        <= s1_d;
        vld_pipe[1] <= 1'b1;
      end else if (vld_pipe[1] & adv2) begin
        vld_pipe[1] <= 1'b0;
      end
      // stage 2 refills from stage 1 whenever it can move; drains only when stage 1 is empty
      if (vld_pipe[1] & adv2) begin
        res_q       <= res_d;
        vld_pipe[2] <= 1'b1;
      end else if (vld_pipe[2] & s.out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul_sqrt_2.sv
// Directed bench for mul_sqrt_2 (W=8): reset, stream, saturation/wrap, backpressure,
// full-pipe simultaneous transfers and mid-stream reset, with an output scoreboard.
module tb_mul_sqrt_2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_sqrt_2_if #(.N(3)) bus();
  mul_sqrt_2 #(.N(3)) u_dut (.clk(clk), .rst(rst), .s(bus));

  typedef struct {
    int d;
    int s;
    int c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   nvec = 0, nmis = 0, cyc = 0, nsent = 0, nrecv = 0, nflush = 0;
  bit   lat_chk = 1'b0;
  bit   acc;
  int   idx, held;
  int   stream_v[5] = '{0, 64, -64, 45, -1};
  int   bp_v[5]     = '{10, 20, 30, -10, 1};

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // floor(x / 2^k) written as integer division, independent of shift operators
  function automatic int fl(input int x, input int k);
    int p;
    p = 1 << k;
    if (x >= 0) return x / p;
    return -((-x + p - 1) / p);
  endfunction

  function automatic exp_t model(input int x);
    exp_t r;
    int   sum;
    sum = x + fl(x, 2) + fl(x, 3) + fl(x, 5) + fl(x, 7);
    r.c = 0;
`ifdef MUL_SQRT_2_SAT_EN
    if (sum > 127)       begin r.d = 127;  r.s = 1; end
    else if (sum < -128) begin r.d = -128; r.s = 1; end
    else                 begin r.d = sum;  r.s = 0; end
`else
    r.d = sum & 255;
    if (r.d > 127) r.d = r.d - 256;
    r.s = 0;
`endif
    return r;
  endfunction

  // scoreboard: everything sampled at negedge, transfers complete on the next posedge
  always @(negedge clk) begin
    if (rst) begin
      nflush = nflush + exp_q.size();
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected out", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          chk("out_data", bus.out_data, e_mon.d);
          chk("out_sat", bus.out_sat, e_mon.s);
          if (lat_chk) chk("latency", cyc - e_mon.c, 2);
        end
        nrecv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e_mon   = model(bus.in_data);
        e_mon.c = cyc;
        exp_q.push_back(e_mon);
        nsent++;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready && !rst;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    bus.in_data  = 8'(x);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    if (!acc) chk("send timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'sd5;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst out_data", bus.out_data, 0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst out_sat", bus.out_sat, 0);

    lat_chk = 1'b1;
    foreach (stream_v[i]) send(stream_v[i]);
    drain();
    lat_chk = 1'b0;

    send(100);
    send(-128);
    send(127);
    drain();

    bus.out_ready = 1'b0;
    idx  = 0;
    held = 0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(bp_v[idx]);
      tick();
      if (acc) idx++;
      if (k == 1) begin
        held = bus.out_data;
        chk("bp first out", held, 13);
      end
      if (k >= 2) begin
        chk("bp hold data", bus.out_data, held);
        chk("bp hold valid", bus.out_valid, 1);
      end
    end
    chk("bp accepts", idx, 2);
    chk("bp in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(bp_v[idx]);
      tick();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chk("bp all accepted", idx, 5);
    drain();

    bus.out_ready = 1'b0;
    send(int'($urandom_range(0, 255)) - 128);
    send(int'($urandom_range(0, 255)) - 128);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom_range(0, 255));
      #1;
      chk("sim in_ready", bus.in_ready, 1);
      chk("sim out_valid", bus.out_valid, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    drain();

    bus.out_ready = 1'b0;
    send(64);
    send(-64);
    rst = 1'b1;
    tick();
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("midrst out_valid", bus.out_valid, 0);
      tick();
    end
    send(45);
    drain();
    chk("flushed", nflush, 2);
    chk("out count", nrecv, nsent - nflush);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
